// File: rtl/sisc_mem_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package sisc_mem_pkg;

  localparam int unsigned AW_DEF     = 16;
  localparam int unsigned DW_DEF     = 16;
  localparam int unsigned LAT_DEF    = 2;
  localparam int unsigned STREAK_MAX = 2;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned STREAK_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Down-counter timing the memory read latency; zero_c marks the final wait cycle.
module mem_lat_counter
  import sisc_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load takes precedence; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port memory.
module mem_arbiter
  import sisc_mem_pkg::*;
#(
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned LAT = LAT_DEF   // legal range 1..7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_e          state_q, state_d;
  logic                grant_d_q, grant_d_d;   // 1: data port owns the transaction
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [DW-1:0]       i_rdata_q, i_rdata_d;
  logic [DW-1:0]       d_rdata_q, d_rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                busy_q, busy_d;
  logic                cnt_load, cnt_dec, cnt_zero_c;
  logic                pick_d;

  mem_lat_counter u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(LAT - 1)),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero_c)
  );

  // Next-state, arbitration and registered-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d_d = grant_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    streak_d  = streak_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    pick_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          // Data wins ties until it has won STREAK_MAX times in a row over a waiting fetch.
          pick_d    = d_req && !(i_req && (streak_q == STREAK_W'(STREAK_MAX)));
          grant_d_d = pick_d;
          if (pick_d) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
            if (!i_req) begin
              streak_d = '0;
            end else if (streak_q != STREAK_W'(STREAK_MAX)) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end else begin
            addr_d   = i_addr;
            wdata_d  = '0;
            we_d     = 1'b0;
            streak_d = '0;
          end
          mem_en_d = 1'b1;
          mem_we_d = pick_d && d_we;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_zero_c) begin
          state_d = ST_RESP;
          i_ack_d = !grant_d_q;
          d_ack_d = grant_d_q;
          if (!we_q) begin
            if (grant_d_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              i_rdata_d = mem_rdata;
            end
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_d_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      streak_q  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_d_q <= grant_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      streak_q  <= streak_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios, random traffic, LAT=1/7 builds.
module tb_mem_arbiter;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 2;

  typedef struct {
    bit            is_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            grant_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_ack, d_ack, mem_en, mem_we, busy;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat_done = 0;

  logic [DW-1:0] dev_mem [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  exp_t q[$];
  bit   ack_log[$];
  int   free_cyc = 0;
  int   streak   = 0;
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  int   i_st = 0, d_st = 0, i_due = 0, d_due = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory device: read data valid only in the cycle LAT after the strobe.
  int            dev_due = -1;
  logic [AW-1:0] dev_raddr = '0;
  always @(negedge clk) begin
    if (rst) begin
      dev_due = -1;
    end else if (mem_en) begin
      if (mem_we) dev_mem[mem_addr] = mem_wdata;
      else begin
        dev_due   = cyc + int'(LAT);
        dev_raddr = mem_addr;
      end
    end
    mem_rdata = (cyc == dev_due) ? dev_mem[dev_raddr] : DW'($urandom);
  end

  // Transaction-level reference: one access at a time, LAT+3 cycles each.
  task automatic model_eval();
    exp_t e;
    bit   pick_d;
    if (rst || cyc < free_cyc || !(i_req || d_req)) return;
    pick_d = d_req && !(i_req && streak == 2);
    if (pick_d) streak = i_req ? ((streak < 2) ? streak + 1 : 2) : 0;
    else        streak = 0;
    e.is_d      = pick_d;
    e.we        = pick_d && d_we;
    e.addr      = pick_d ? d_addr : i_addr;
    e.wdata     = d_wdata;
    e.rdata     = ref_mem[e.addr];
    e.grant_cyc = cyc;
    if (e.we) ref_mem[e.addr] = d_wdata;
    q.push_back(e);
    free_cyc = cyc + int'(LAT) + 3;
    if (pick_d) begin d_st = 2; d_due = cyc + int'(LAT) + 2; end
    else        begin i_st = 2; i_due = cyc + int'(LAT) + 2; end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drain();
    i_req = 1'b0;
    d_req = 1'b0;
    for (int n = 0; n < 40 && q.size() > 0; n++) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d transactions outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_i_ack"}, i_ack, 0);
    check({tag, "_d_ack"}, d_ack, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_i_rdata"}, i_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    q.delete();
    streak      = 0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    free_cyc = cyc;
  endtask

  // Monitor: per-cycle output checks; pops the scoreboard on every ack.
  always @(negedge clk) begin
    if (!rst) begin
      bit   have;
      exp_t f;
      int   ack_at;
      bit   exp_busy;
      have     = (q.size() > 0);
      if (have) f = q[0];
      ack_at   = f.grant_cyc + int'(LAT) + 2;
      exp_busy = have && (cyc > f.grant_cyc) && (cyc <= ack_at);
      check("busy", busy, exp_busy);
      check("mem_en", mem_en, have && (cyc == f.grant_cyc + 1));
      check("mem_we", mem_we, have && (cyc == f.grant_cyc + 1) && f.we);
      if (exp_busy) check("mem_addr", mem_addr, f.addr);
      if (exp_busy && f.we) check("mem_wdata", mem_wdata, f.wdata);
      check("dual_ack", i_ack && d_ack, 0);
      if (i_ack || d_ack) begin
        ack_log.push_back(d_ack);
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b, expected no ack (cycle %0d)", i_ack, d_ack, cyc);
        end else begin
          check("ack_cycle", cyc, ack_at);
          check("ack_port", d_ack, f.is_d);
          if (!f.we) begin
            if (f.is_d) exp_d_rdata = f.rdata;
            else        exp_i_rdata = f.rdata;
          end
          void'(q.pop_front());
        end
      end else if (have && cyc > ack_at) begin
        checks++;
        errors++;
        $display("FAIL missing_ack: no ack, expected one at cycle %0d (now %0d)", ack_at, cyc);
        void'(q.pop_front());
      end
      check("i_rdata", i_rdata, exp_i_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);
    end
  end

  // LAT=1 and LAT=7 builds: single fetch, ack cycle and sampled data.
  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int unsigned LATG = (g == 0) ? 1 : 7;
    logic          g_ireq = 1'b0;
    logic [AW-1:0] g_iaddr = '0;
    logic          g_iack, g_dack, g_en, g_we, g_busy;
    logic [DW-1:0] g_irdata, g_drdata, g_wdata;
    logic [DW-1:0] g_mrdata;
    logic [AW-1:0] g_addr;
    int            g_due = -1;

    mem_arbiter #(.AW(AW), .DW(DW), .LAT(LATG)) u_dut (
      .clk(clk), .rst(rst),
      .i_req(g_ireq), .i_addr(g_iaddr), .i_ack(g_iack), .i_rdata(g_irdata),
      .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
      .d_ack(g_dack), .d_rdata(g_drdata),
      .mem_en(g_en), .mem_we(g_we), .mem_addr(g_addr),
      .mem_wdata(g_wdata), .mem_rdata(g_mrdata), .busy(g_busy)
    );

    always @(negedge clk) begin
      if (rst) g_due = -1;
      else if (g_en) g_due = cyc + int'(LATG);
      g_mrdata = (cyc == g_due) ? (g_addr ^ 16'hC0DE) : DW'($urandom);
    end

    initial begin
      int start;
      int seen;
      seen = -1;
      #1;
      wait (rst == 1'b0);
      @(posedge clk);
      #1;
      g_ireq  = 1'b1;
      g_iaddr = 16'h0077;
      start   = cyc;
      @(posedge clk);
      #1;
      g_ireq = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (g_iack) begin
          seen = cyc;
          break;
        end
      end
      check($sformatf("lat%0d_ack_cycle", LATG), seen, start + int'(LATG) + 2);
      check($sformatf("lat%0d_rdata", LATG), g_irdata, 16'h0077 ^ 16'hC0DE);
      check($sformatf("lat%0d_no_dack", LATG), {g_dack, g_we, g_busy}, 3'b001);
      check($sformatf("lat%0d_drdata", LATG), g_drdata, 0);
      lat_done++;
    end
  end

  // Main stimulus.
  initial begin
    bit exp_pat [6];
    exp_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int a = 0; a < 65536; a++) begin
      dev_mem[a] = DW'(a * 40503 + 7);
      ref_mem[a] = dev_mem[a];
    end
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    #2;
    check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    free_cyc = cyc;

    // Fetch read with known data.
    dev_mem[16'h0010] = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;
    i_req = 1; i_addr = 16'h0010;
    tick();
    i_req = 0;
    run(6);
    check("fetch_beef", i_rdata, 16'hBEEF);

    // Data write: d_rdata must hold.
    d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
    tick();
    d_req = 0;
    run(6);
    check("write_landed", dev_mem[16'h0020], 16'h1234);

    // Data read with request dropped in cycle 2.
    d_req = 1; d_we = 0; d_addr = 16'h0030;
    run(2);
    d_req = 0;
    run(5);

    // Both ports held: D, D, I repeating.
    ack_log.delete();
    i_req = 1; i_addr = 16'h0050;
    d_req = 1; d_we = 0; d_addr = 16'h0040;
    run(6 * (LAT + 3) + 1);
    drain();
    checks++;
    if (ack_log.size() < 6) begin
      errors++;
      $display("FAIL grant_order_count: got %0d acks, expected at least 6", ack_log.size());
    end else begin
      for (int k = 0; k < 6; k++) check($sformatf("grant_order_%0d", k), ack_log[k], exp_pat[k]);
    end

    // Reset during WAIT with streak at 2; next grant must go to data.
    i_req = 1; d_req = 1; d_we = 0; d_addr = 16'h0060; i_addr = 16'h0070;
    run(7);
    do_reset();
    ack_log.delete();
    run(LAT + 3);
    drain();
    check("post_reset_acks", ack_log.size(), 1);
    if (ack_log.size() > 0) check("post_reset_port", ack_log[0], 1);

    // Random traffic.
    i_st = 0; d_st = 0;
    for (int n = 0; n < 600; n++) begin
      if (i_st == 2 && cyc > i_due) i_st = 0;
      if (i_st == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          i_st = 1; i_req = 1; i_addr = AW'($urandom_range(0, 31));
        end else i_req = 0;
      end else if (i_st == 2) i_req = ($urandom_range(0, 3) != 0);
      if (d_st == 2 && cyc > d_due) d_st = 0;
      if (d_st == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          d_st = 1; d_req = 1; d_we = ($urandom_range(0, 2) == 0);
          d_addr = AW'($urandom_range(0, 31)); d_wdata = DW'($urandom);
        end else d_req = 0;
      end else if (d_st == 2) d_req = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    for (int n = 0; n < 100 && lat_done < 2; n++) @(posedge clk);
    checks++;
    if (lat_done < 2) begin
      errors++;
      $display("FAIL lat_builds_done: got %0d, expected 2", lat_done);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
